frame_dispatch_ctrl: RTL and testbench
======================================

# frame_dispatch_ctrl

Sequences one CNN inference per incoming frame. Accepts the 112x112 vsync-framed 8-bit pixel stream from the image source (simulation generator or camera binarizer), decimates it 4:1 in both axes into a 28x28 image, writes that image into the CNN input buffer, pulses the CNN start, and waits for done or timeout. Frames that arrive while the CNN is busy are dropped and counted. Sits between the pixel source and the CNN core.

## Interface
- IMG_W, 112, input pixels per line
- IMG_H, 112, input lines per frame
- DS_SHIFT, 2, log2 of decimation factor (4)
- TIMEOUT_CYC, 1_000_000, max cycles in WAIT_DONE before abort
- sclk  input  1  system clock
- s_rst_n  input  1  asynchronous active-low reset
- vsync  input  1  single-cycle frame-start pulse
- bin_data_vld  input  1  pixel valid
- bin_data  input  8  pixel value
- buf_wr_en  output  1  CNN input buffer write strobe
- buf_wr_addr  output  10  buffer address, 0..783, row-major
- buf_wr_data  output  8  buffer write data
- cnn_start  output  1  single-cycle inference start
- cnn_done  input  1  single-cycle inference complete
- cnn_result  input  4  recognized digit, valid with cnn_done
- result_vld  output  1  single-cycle result strobe
- result  output  4  last recognized digit, held
- timeout_err  output  1  single-cycle pulse on WAIT_DONE timeout
- frame_drop_cnt  output  8  dropped frames, saturating at 255
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, CAPTURE, START, WAIT_DONE.
- IDLE: vsync -> CAPTURE; row/col counters and write address cleared. Pixels ignored.
- CAPTURE: each bin_data_vld advances col (0..IMG_W-1); on col wrap, row increments. Pixel sampled when row[1:0]==0 and col[1:0]==0; sample written at buf_wr_addr, then address increments.
- Write of address 783 (row 108, col 108) -> START; remaining pixels of the frame ignored.
- START: cnn_start high one cycle -> WAIT_DONE.
- WAIT_DONE: cnn_done -> result <= cnn_result, result_vld pulse, -> IDLE. Cycle counter reaching TIMEOUT_CYC -> timeout_err pulse, result unchanged, -> IDLE.
- vsync in CAPTURE: frame aborted, counters and address cleared, stays in CAPTURE, frame_drop_cnt +1.
- vsync in START or WAIT_DONE: frame_drop_cnt +1, no state change.
- vsync and bin_data_vld in same cycle: vsync wins, that pixel discarded.
- cnn_done outside WAIT_DONE ignored. cnn_done on the timeout cycle: done wins, no timeout_err.
- frame_drop_cnt saturates at 255; never wraps.
- Reset mid-operation: all state lost, IDLE, partial buffer contents irrelevant.

## Timing
- Reset values: buf_wr_en 0, buf_wr_addr 0, buf_wr_data 0, cnn_start 0, result_vld 0, result 0, timeout_err 0, frame_drop_cnt 0, busy 0.
- All outputs registered.
- Pixel-to-write latency: 1 cycle (buf_wr_en/addr/data valid the cycle after the sampled bin_data_vld).
- cnn_start asserted the cycle after the 784th buf_wr_en; buffer write completes before start.
- result_vld the cycle after cnn_done; busy falls the same cycle.
- vsync accepted in IDLE: busy high the next cycle.
- Timeout counter starts at 0 on WAIT_DONE entry; timeout_err asserted after exactly TIMEOUT_CYC cycles without done.

## Structure
- Shared package: IMG_W/IMG_H defaults, OUT_W=28, PIX_NUM=784, buffer address width 10, state enum.
- Sub-module ds_addr_gen: row/col counters, decimation test, write-address counter, last-pixel flag; controller FSM, timeout counter and drop counter in top.

## Test plan
- Full 112x112 frame, pixel value = (row>>2)*28+(col>>2) low 8 bits -> 784 writes, addr k carries k[7:0], cnn_start one cycle after write 783.
- cnn_done with cnn_result=7 10 cycles after start -> result_vld one cycle later, result=7, busy 0.
- Second vsync at row 50 of capture -> frame_drop_cnt=1, address restarts at 0, full 784 writes from new frame.
- 300 vsyncs during WAIT_DONE -> frame_drop_cnt=255, no state change.
- TIMEOUT_CYC=100, no cnn_done -> timeout_err at cycle 100 of WAIT_DONE, result unchanged, IDLE; cnn_done on cycle 100 -> result_vld, no timeout_err.
- s_rst_n low during CAPTURE after 400 writes -> all outputs reset values; next vsync restarts at address 0.

Source files
------------

// File: rtl/frame_dispatch_ctrl_pkg.sv
// Shared constants, FSM encoding and helpers for the frame dispatch controller.
// The default geometry maps a 112x112 frame onto a 28x28 CNN input buffer.
package frame_dispatch_ctrl_pkg;

  localparam int unsigned IMG_W_DEF    = 112;
  localparam int unsigned IMG_H_DEF    = 112;
  localparam int unsigned DS_SHIFT_DEF = 2;
  localparam int unsigned OUT_W        = IMG_W_DEF >> DS_SHIFT_DEF;
  localparam int unsigned PIX_NUM      = OUT_W * (IMG_H_DEF >> DS_SHIFT_DEF);
  localparam int unsigned ADDR_W       = 10;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t StIdle     = 2'd0;
  localparam fsm_state_t StCapture  = 2'd1;
  localparam fsm_state_t StStart    = 2'd2;
  localparam fsm_state_t StWaitDone = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_dispatch_ctrl_ds_addr_gen.sv
// Row/column tracking, 2^DS_SHIFT decimation and buffer write-address generation.
// `sample` is combinational; the parent registers the actual buffer write.
module frame_dispatch_ctrl_ds_addr_gen
  import frame_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned DS_SHIFT = DS_SHIFT_DEF
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              clr,
  input  logic              pix_vld,
  output logic              sample,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned NUM   = (IMG_W >> DS_SHIFT) * (IMG_H >> DS_SHIFT);

  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] addr_q;

  assign sample = pix_vld && (col_q[DS_SHIFT-1:0] == '0) && (row_q[DS_SHIFT-1:0] == '0);
  assign addr   = addr_q;
  assign last   = (addr_q == ADDR_W'(NUM - 1));

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (clr) begin
      col_q  <= '0;
      row_q  <= '0;
      addr_q <= '0;
    end else if (pix_vld) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= row_q + ROW_W'(1);
      end else begin
        col_q <= col_q + COL_W'(1);
      end
      if (sample) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/frame_dispatch_ctrl.sv
// Per-frame CNN sequencer: capture a decimated frame into the CNN input buffer,
// start inference, then wait for done or timeout. Frames arriving while busy are dropped.
module frame_dispatch_ctrl
  import frame_dispatch_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W       = IMG_W_DEF,
  parameter int unsigned IMG_H       = IMG_H_DEF,
  parameter int unsigned DS_SHIFT    = DS_SHIFT_DEF,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic              vsync,
  input  logic              bin_data_vld,
  input  logic [7:0]        bin_data,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [7:0]        buf_wr_data,
  output logic              cnn_start,
  input  logic              cnn_done,
  input  logic [3:0]        cnn_result,
  output logic              result_vld,
  output logic [3:0]        result,
  output logic              timeout_err,
  output logic [7:0]        frame_drop_cnt,
  output logic              busy
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);

  fsm_state_t        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              pix_vld, ag_clr, ag_sample, ag_last;
  logic [ADDR_W-1:0] ag_addr;
  logic              drop_inc, cnn_start_d, result_vld_d, timeout_d;
  logic [3:0]        result_d;

  // vsync has priority over a coincident pixel, which is discarded.
  assign pix_vld = (state_q == StCapture) && bin_data_vld && !vsync;
  assign ag_clr  = (state_q == StIdle) || ((state_q == StCapture) && vsync);

  frame_dispatch_ctrl_ds_addr_gen #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .DS_SHIFT (DS_SHIFT)
  ) u_ds_addr_gen (
    .sclk    (sclk),
    .s_rst_n (s_rst_n),
    .clr     (ag_clr),
    .pix_vld (pix_vld),
    .sample  (ag_sample),
    .addr    (ag_addr),
    .last    (ag_last)
  );

  always_comb begin
    state_d      = state_q;
    tmr_d        = tmr_q;
    drop_inc     = 1'b0;
    cnn_start_d  = 1'b0;
    result_vld_d = 1'b0;
    timeout_d    = 1'b0;
    result_d     = result;
    case (state_q)
      StIdle: begin
        if (vsync) state_d = StCapture;
      end
      StCapture: begin
        if (vsync) begin
          drop_inc = 1'b1;
        end else if (ag_sample && ag_last) begin
          state_d = StStart;
        end
      end
      StStart: begin
        drop_inc    = vsync;
        cnn_start_d = 1'b1;
        tmr_d       = '0;
        state_d     = StWaitDone;
      end
      StWaitDone: begin
        drop_inc = vsync;
        // done takes precedence on the final timeout cycle
        if (cnn_done) begin
          result_d     = cnn_result;
          result_vld_d = 1'b1;
          state_d      = StIdle;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state_q        <= StIdle;
      tmr_q          <= '0;
      buf_wr_en      <= 1'b0;
      buf_wr_addr    <= '0;
      buf_wr_data    <= '0;
      cnn_start      <= 1'b0;
      result_vld     <= 1'b0;
      result         <= '0;
      timeout_err    <= 1'b0;
      frame_drop_cnt <= '0;
      busy           <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      buf_wr_en   <= ag_sample;
      if (ag_sample) begin
        buf_wr_addr <= ag_addr;
        buf_wr_data <= bin_data;
      end
      cnn_start   <= cnn_start_d;
      result_vld  <= result_vld_d;
      result      <= result_d;
      timeout_err <= timeout_d;
      if (drop_inc) begin
        frame_drop_cnt <= sat_inc8(frame_drop_cnt);
      end
      busy        <= (state_d != StIdle);
    end
  end

endmodule

// File: tb/tb_frame_dispatch_ctrl.sv
// Randomized bench for frame_dispatch_ctrl with a frame-level reference model of the
// expected buffer writes and event timing.
module tb_frame_dispatch_ctrl;

  localparam int          W          = 112;
  localparam int          H          = 112;
  localparam int unsigned TB_TIMEOUT = 400;

  logic       sclk = 1'b0;
  logic       s_rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       bin_data_vld = 1'b0;
  logic [7:0] bin_data = 8'h00;
  logic       cnn_done = 1'b0;
  logic [3:0] cnn_result = 4'h0;
  logic       buf_wr_en, cnn_start, result_vld, timeout_err, busy;
  logic [9:0] buf_wr_addr;
  logic [7:0] buf_wr_data, frame_drop_cnt;
  logic [3:0] result;

  frame_dispatch_ctrl #(
    .IMG_W       (W),
    .IMG_H       (H),
    .DS_SHIFT    (2),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .sclk           (sclk),
    .s_rst_n        (s_rst_n),
    .vsync          (vsync),
    .bin_data_vld   (bin_data_vld),
    .bin_data       (bin_data),
    .buf_wr_en      (buf_wr_en),
    .buf_wr_addr    (buf_wr_addr),
    .buf_wr_data    (buf_wr_data),
    .cnn_start      (cnn_start),
    .cnn_done       (cnn_done),
    .cnn_result     (cnn_result),
    .result_vld     (result_vld),
    .result         (result),
    .timeout_err    (timeout_err),
    .frame_drop_cnt (frame_drop_cnt),
    .busy           (busy)
  );

  always #5 sclk = ~sclk;

  int unsigned cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  logic [17:0] got_q[$];
  logic [17:0] exp_q[$];
  logic [7:0]  img[H][W];
  int unsigned last_wr_cyc = 0, start_cyc = 0, to_cyc = 0;
  int          start_cnt = 0, rv_cnt = 0, to_cnt = 0;

  always @(negedge sclk) begin
    if (buf_wr_en) begin
      got_q.push_back({buf_wr_addr, buf_wr_data});
      last_wr_cyc <= cyc;
    end
    if (cnn_start) begin
      start_cnt <= start_cnt + 1;
      start_cyc <= cyc;
    end
    if (result_vld) rv_cnt <= rv_cnt + 1;
    if (timeout_err) begin
      to_cnt <= to_cnt + 1;
      to_cyc <= cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_wr_en"}, 32'(buf_wr_en), 0);
    check_eq({pfx, "_wr_addr"}, 32'(buf_wr_addr), 0);
    check_eq({pfx, "_wr_data"}, 32'(buf_wr_data), 0);
    check_eq({pfx, "_cnn_start"}, 32'(cnn_start), 0);
    check_eq({pfx, "_result_vld"}, 32'(result_vld), 0);
    check_eq({pfx, "_result"}, 32'(result), 0);
    check_eq({pfx, "_timeout_err"}, 32'(timeout_err), 0);
    check_eq({pfx, "_drop_cnt"}, 32'(frame_drop_cnt), 0);
    check_eq({pfx, "_busy"}, 32'(busy), 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(255));
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'((r / 4) * 28 + (c / 4));
  endtask

  // Reference: every 4th pixel of every 4th line among the first nrows lines, row-major.
  task automatic expect_rows(input int nrows);
    int k = 0;
    for (int r = 0; r < nrows; r += 4)
      for (int c = 0; c < W; c += 4) begin
        exp_q.push_back({k[9:0], img[r][c]});
        k++;
      end
  endtask

  task automatic send_pixels(input int npix);
    for (int p = 0; p < npix; p++) begin
      if ($urandom_range(15) == 0) begin
        bin_data_vld = 1'b0;
        tick();
      end
      bin_data_vld = 1'b1;
      bin_data     = img[p / W][p % W];
      tick();
    end
    bin_data_vld = 1'b0;
  endtask

  task automatic pulse_vsync(input bit with_pix);
    vsync        = 1'b1;
    bin_data_vld = with_pix;
    bin_data     = 8'hEE;
    tick();
    vsync        = 1'b0;
    bin_data_vld = 1'b0;
  endtask

  task automatic wait_start(output int unsigned s, output bit ok);
    ok = 1'b0;
    s  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cnn_start) begin
        s  = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic compare_writes(input string tag);
    int n;
    int f0;
    check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    n  = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    f0 = failures;
    for (int i = 0; i < n; i++) begin
      check_eq({tag, "_addr_data"}, 32'(got_q[i]), 32'(exp_q[i]));
      if (failures != f0) break;
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int unsigned s;
    bit          ok;

    repeat (3) tick();
    check_reset_outputs("rst");
    s_rst_n = 1'b1;
    tick();

    // Frame A aborted at line 50 by a vsync that also carries a pixel.
    fill_random();
    expect_rows(50);
    pulse_vsync(1'b0);
    send_pixels(50 * W);
    pulse_vsync(1'b1);
    check_eq("drop_after_abort", 32'(frame_drop_cnt), 1);
    check_eq("busy_after_abort", 32'(busy), 1);

    // Frame B: pattern image, done with digit 7 ten cycles after start.
    fill_pattern();
    expect_rows(H);
    send_pixels(108 * W + 109);
    wait_start(s, ok);
    check_eq("b_start_seen", 32'(ok), 1);
    #1;
    check_eq("b_start_after_last_wr", last_wr_cyc + 1, start_cyc);
    compare_writes("b_wr");
    repeat (10) tick();
    check_eq("b_busy_waiting", 32'(busy), 1);
    cnn_done   = 1'b1;
    cnn_result = 4'd7;
    tick();
    cnn_done = 1'b0;
    check_eq("b_result_vld", 32'(result_vld), 1);
    check_eq("b_result", 32'(result), 7);
    check_eq("b_busy_low", 32'(busy), 0);
    check_eq("b_no_timeout", 32'(timeout_err), 0);
    tick();
    check_eq("b_result_vld_pulse", 32'(result_vld), 0);
    // done while idle must be ignored
    cnn_done   = 1'b1;
    cnn_result = 4'd3;
    tick();
    cnn_done = 1'b0;
    repeat (2) tick();
    #1;
    check_eq("idle_done_rv_cnt", 32'(rv_cnt), 1);
    check_eq("idle_done_result", 32'(result), 7);
    check_eq("b_start_cnt", 32'(start_cnt), 1);

    // Frame C: full frame with trailing pixels ignored, no done -> timeout.
    fill_random();
    expect_rows(H);
    pulse_vsync(1'b0);
    send_pixels(W * H);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      #1;
      if (to_cnt != 0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check_eq("c_timeout_seen", 32'(ok), 1);
    check_eq("c_timeout_latency", to_cyc - start_cyc, TB_TIMEOUT);
    check_eq("c_result_kept", 32'(result), 7);
    check_eq("c_rv_cnt", 32'(rv_cnt), 1);
    check_eq("c_start_cnt", 32'(start_cnt), 2);
    compare_writes("c_wr");
    tick();
    check_eq("c_busy_idle", 32'(busy), 0);

    // Frame D: 300 vsyncs while waiting, then done on the last allowed cycle.
    fill_random();
    expect_rows(H);
    pulse_vsync(1'b0);
    check_eq("d_busy_after_vsync", 32'(busy), 1);
    send_pixels(108 * W + 109);
    wait_start(s, ok);
    check_eq("d_start_seen", 32'(ok), 1);
    repeat (300) begin
      vsync = 1'b1;
      tick();
    end
    vsync = 1'b0;
    check_eq("d_drop_saturated", 32'(frame_drop_cnt), 255);
    check_eq("d_busy_during_burst", 32'(busy), 1);
    repeat (TB_TIMEOUT - 301) tick();
    cnn_done   = 1'b1;
    cnn_result = 4'd5;
    tick();
    cnn_done = 1'b0;
    check_eq("d_result_vld", 32'(result_vld), 1);
    check_eq("d_result", 32'(result), 5);
    check_eq("d_no_timeout_err", 32'(timeout_err), 0);
    check_eq("d_busy_low", 32'(busy), 0);
    repeat (5) tick();
    #1;
    check_eq("d_to_cnt", 32'(to_cnt), 1);
    check_eq("d_rv_cnt", 32'(rv_cnt), 2);
    check_eq("d_drop_held", 32'(frame_drop_cnt), 255);
    compare_writes("d_wr");

    // Frame E: reset after 400 writes, then frame F restarts at address 0.
    fill_random();
    pulse_vsync(1'b0);
    send_pixels(56 * W + 29);
    repeat (3) tick();
    #1;
    check_eq("e_writes_before_rst", 32'(got_q.size()), 400);
    s_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    s_rst_n = 1'b1;
    tick();
    got_q.delete();
    exp_q.delete();
    fill_random();
    expect_rows(8);
    pulse_vsync(1'b0);
    send_pixels(8 * W);
    repeat (3) tick();
    #1;
    compare_writes("f_wr");
    check_eq("f_drop_cnt", 32'(frame_drop_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
